// File: rtl/cdc_pkg.sv
// Shared types and constants for the flag-based clock-domain-crossing blocks.
// The state type is visible to both the source FSM and its debug port.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam POL_POS = "POS";
  localparam POL_NEG = "NEG";

endpackage

// File: rtl/async_flag_source_if.sv
// Four-phase request/acknowledge pair crossing from the source to the destination domain.
// Handshake: master raises a_flag (active level), slave answers a_ack=1, master drops
// a_flag, slave drops a_ack=0; a new request starts only once a_ack is seen low again.
interface async_flag_source_if;
  logic a_flag;
  logic a_ack;

  modport master (output a_flag, input a_ack);
  modport slave  (input a_flag, output a_ack);
endinterface

// File: rtl/cdc_sync_bit.sv
// Multi-stage single-bit synchronizer; the last stage is the only safe output.
// Shared by the send and receive halves of the flag crossing.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "cdc_sync_bit: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_flag_source.sv
// Source side of a four-phase flag crossing: counts request events and issues one
// handshake per event toward the destination, with a saturating pending counter.
module async_flag_source
  import cdc_pkg::*;
#(
  parameter     POLARITY = POL_POS,
  parameter int SYNC_FF  = 3,
  parameter int PEND_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   event_in,
  input  logic                   clr_overflow,
  async_flag_source_if.master    hs,
  output logic                   busy,
  output logic [PEND_W-1:0]      pend_count,
  output logic                   done,
  output logic                   overflow,
  output logic                   tp,
  output state_t                 state_dbg
);

  if (SYNC_FF < 2) begin : g_bad_sync
    $fatal(1, "async_flag_source: SYNC_FF must be at least 2");
  end
  if ((POLARITY != POL_POS) && (POLARITY != POL_NEG)) begin : g_bad_pol
    $fatal(1, "async_flag_source: POLARITY must be \"POS\" or \"NEG\"");
  end

  localparam logic              ACT_LOW  = (POLARITY == POL_NEG);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic              ack_s;
  logic              flag_q;
  logic              done_q;
  logic              ovf_q;
  logic [PEND_W-1:0] pend_q;
  logic              have_pend, issue, take_pend, drop, accept;

  cdc_sync_bit #(.STAGES(SYNC_FF)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (hs.a_ack),
    .q       (ack_s)
  );

  // An event that issues straight from an empty counter is consumed without being counted.
  always_comb begin
    have_pend = (pend_q != '0);
    issue     = (state_q == IDLE) && !ack_s && (have_pend || event_in);
    take_pend = issue && have_pend;
    drop      = event_in && (pend_q == PEND_MAX) && !issue;
    accept    = event_in && !(issue && !have_pend) && !drop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue)  state_d = REQ;
      REQ:     if (ack_s)  state_d = RELEASE;
      RELEASE: if (!ack_s) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= (state_d == REQ);
      done_q  <= (state_q == RELEASE) && (state_d == IDLE);
      if (accept && !take_pend)      pend_q <= pend_q + 1'b1;
      else if (take_pend && !accept) pend_q <= pend_q - 1'b1;
      // A fresh drop outranks a clear arriving in the same cycle.
      if (drop)              ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign hs.a_flag  = flag_q ^ ACT_LOW;
  assign busy       = (state_q != IDLE);
  assign pend_count = pend_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign tp         = ack_s;
  assign state_dbg  = state_q;

endmodule
